lookup_table_writer: RTL and testbench
======================================

LOOKUP_TABLE_WRITER -- requirements
Module: lookup_table_writer

Interface
REQ-001 SHALL have parameter STAGE_ID, default 0: 5-bit stage number matched against the header module-ID bits [7:3].
REQ-002 SHALL have parameter LOOKUP_ID, default 2: 3-bit sub-module number matched against the header module-ID bits [2:0].
REQ-003 SHALL have parameters C_S_AXIS_DATA_WIDTH 512, C_S_AXIS_TUSER_WIDTH 128, KEY_LEN 197, ACT_LEN 625, TBL_DEPTH 16.
REQ-004 clk  in  1  single clock; all logic on its rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 c_s_axis_tdata/tuser/tkeep/tvalid/tlast  in  512/128/64/1/1  control stream in; no tready, never back-pressured.
REQ-007 c_m_axis_tdata/tuser/tkeep/tvalid/tlast  out  512/128/64/1/1  registered control stream out to the next stage.
REQ-008 cam_we  out  1  one-cycle TCAM write strobe.
REQ-009 cam_addr  out  4  TCAM write address.
REQ-010 cam_din / cam_mask  out  197/197  TCAM entry and entry mask.
REQ-011 act_we  out  1  one-cycle action-RAM write strobe.
REQ-012 act_addr  out  4  action-RAM write address.
REQ-013 act_din  out  625  action-RAM write data.

Function
REQ-014 Header beat fields SHALL be: mod_id = tdata[375:368], resv = tdata[383:380], index = tdata[391:384].
REQ-015 A packet SHALL be claimed when, in IDLE, tvalid=1, mod_id=={STAGE_ID,LOOKUP_ID}, and resv is 0 (TCAM) or 2 (action); all other packets SHALL be forwarded.
REQ-016 States: IDLE, FWD, CAM_ENT, CAM_MSK, ACT_LO, ACT_HI, DROP; state SHALL advance only on beats with tvalid=1; tvalid gaps hold state.
REQ-017 Forwarded beats SHALL appear on c_m_axis_* exactly 1 cycle later with all fields unchanged; an unclaimed header with tlast=0 enters FWD until the tlast beat.
REQ-018 Claimed packets (all beats, header included) SHALL NOT be forwarded; c_m_axis_tvalid=0 for those cycles.
REQ-019 A claimed header with index[7:4]!=0 SHALL enter DROP (or stay in IDLE if tlast=1); DROP consumes beats to tlast and makes no writes.
REQ-020 TCAM: header -> CAM_ENT; the entry beat latches tdata[196:0] -> CAM_MSK; the mask beat latches tdata[196:0]; cam_we=1 on the next cycle with cam_addr = index[3:0] + pair_count (mod 16).
REQ-021 Action: header -> ACT_LO; the lo beat latches act_din[511:0] -> ACT_HI; the hi beat latches act_din[624:512] = tdata[112:0]; act_we=1 on the next cycle with act_addr = index[3:0] + entry_count (mod 16).
REQ-022 After a completed pair or entry, tlast=0 SHALL return to CAM_ENT/ACT_LO with count+1; tlast=1 SHALL return to IDLE.
REQ-023 tlast on an entry beat (CAM_ENT, ACT_LO) SHALL discard the partial entry with no write and return to IDLE.
REQ-024 A header with tlast=1 SHALL produce no write and stay in IDLE.
REQ-025 Address arithmetic SHALL be 4-bit and wrap 15 -> 0.
REQ-026 cam_din, cam_mask and act_din SHALL hold their last written values between strobes; strobes SHALL be exactly 1 cycle wide.
REQ-027 A new header arriving the cycle after a tlast SHALL be accepted with no idle cycle required.

Reset
REQ-028 While rst_n=0: state=IDLE; counters=0; every output=0, including all c_m_axis_* fields, cam_we, act_we, addresses and data.
REQ-029 Reset mid-packet SHALL abandon the packet with no partial write; beats after reset are treated as a new header.

Structure
REQ-030 Header field offsets, resv codes (0 TCAM, 2 action) and state encodings SHALL live in the shared control-definitions include used by all RMT stages.
REQ-031 One sub-module, lookup_cfg_hdr_decode, SHALL be the combinational header match and classify logic; the FSM and datapath stay in the top module.

Verification
REQ-032 TCAM packet, STAGE_ID 0 / LOOKUP_ID 2, index 3, 2 pairs, tlast on the 4th data beat -> cam_we at addr 3 then 4 with the correct entry and mask; no c_m_axis_tvalid.
REQ-033 Action packet, index 15, 2 entries (4 data beats) -> act_we at addr 15 then 0, each act_din = {hi[112:0], lo[511:0]}.
REQ-034 Packet with mod_id = {1,2}, 3 beats with a gap cycle -> 3 beats forwarded bit-exact, each delayed 1 cycle; no write strobes.
REQ-035 Claimed TCAM packet with tlast on the entry beat; separately, claimed packet with index 0x12 -> no strobes; the next packet is handled normally.
REQ-036 rst_n low during ACT_HI -> all outputs 0, no act_we; a following action packet writes correctly.

Source files
------------

// File: rtl/lookup_table_writer_pkg.sv
// -----------------------------------------------------------------------------
// lookup_table_writer_pkg
//
// Shared control-stream definitions for the RMT stages. This package holds the
// header field offsets, the reserved-field codes that select the table being
// configured, and the FSM state encoding of the table writer.
//
// Contents:
//   HDR_*_LSB / HDR_*_W : bit positions and widths of the header beat fields
//   RESV_CAM / RESV_ACT : resv codes that claim a packet for TCAM / action RAM
//   state_t             : table-writer FSM states
//   module_id()         : forms the 8-bit {stage, lookup} ID a header must match
// -----------------------------------------------------------------------------
package lookup_table_writer_pkg;

    // Header beat field layout (first beat of every control packet).
    localparam int HDR_MOD_ID_LSB = 368;
    localparam int HDR_MOD_ID_W   = 8;
    localparam int HDR_RESV_LSB   = 380;
    localparam int HDR_RESV_W     = 4;
    localparam int HDR_INDEX_LSB  = 384;
    localparam int HDR_INDEX_W    = 8;

    // Reserved-field codes that select the target table.
    localparam logic [HDR_RESV_W-1:0] RESV_CAM = 4'd0;
    localparam logic [HDR_RESV_W-1:0] RESV_ACT = 4'd2;

    // Table-writer FSM states.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,  // waiting for a header beat
        ST_FWD     = 3'd1,  // forwarding an unclaimed packet to its tlast
        ST_CAM_ENT = 3'd2,  // expecting the TCAM entry beat of a pair
        ST_CAM_MSK = 3'd3,  // expecting the TCAM mask beat of a pair
        ST_ACT_LO  = 3'd4,  // expecting the low 512 bits of an action
        ST_ACT_HI  = 3'd5,  // expecting the high bits of an action
        ST_DROP    = 3'd6   // swallowing a claimed packet with a bad index
    } state_t;

    // Module ID carried in the header: stage number in [7:3], sub-module in [2:0].
    function automatic logic [HDR_MOD_ID_W-1:0] module_id(input int stage, input int lookup);
        return HDR_MOD_ID_W'(((stage & 31) << 3) | (lookup & 7));
    endfunction

endpackage : lookup_table_writer_pkg

// File: rtl/lookup_cfg_hdr_decode.sv
// -----------------------------------------------------------------------------
// lookup_cfg_hdr_decode
//
// Combinational header match and classification for the table writer. Given
// the three header fields it decides whether this stage claims the packet,
// which table the packet targets, and whether the index fits the table.
//
// Ports:
//   mod_id_i    in  8   header module ID {stage, lookup}
//   resv_i      in  4   header reserved field (table selector)
//   index_i     in  8   header table index
//   claim_o     out 1   packet is addressed to this lookup and targets a table
//   is_cam_o    out 1   claimed packet targets the TCAM (else action RAM)
//   idx_ok_o    out 1   index upper bits are zero, so it fits the table
//   base_addr_o out AW  starting table address taken from the index
// -----------------------------------------------------------------------------
module lookup_cfg_hdr_decode
    import lookup_table_writer_pkg::*;
#(
    parameter int STAGE_ID  = 0,
    parameter int LOOKUP_ID = 2,
    parameter int IDX_W     = 4
) (
    input  logic [HDR_MOD_ID_W-1:0] mod_id_i,
    input  logic [HDR_RESV_W-1:0]   resv_i,
    input  logic [HDR_INDEX_W-1:0]  index_i,
    output logic                    claim_o,
    output logic                    is_cam_o,
    output logic                    idx_ok_o,
    output logic [IDX_W-1:0]        base_addr_o
);

    localparam logic [HDR_MOD_ID_W-1:0] MY_ID = module_id(STAGE_ID, LOOKUP_ID);

    logic id_match;

    assign id_match = (mod_id_i == MY_ID);

    always_comb begin
        // NOTE: every output of a combinational block gets a default before any
        // branch, so no path leaves it unassigned and no latch is inferred.
        claim_o  = 1'b0;
        is_cam_o = 1'b0;
        if (id_match) begin
            case (resv_i)
                RESV_CAM: begin
                    claim_o  = 1'b1;
                    is_cam_o = 1'b1;
                end
                RESV_ACT: begin
                    claim_o  = 1'b1;
                end
                default: begin
                    // Other table selectors belong to someone else; forward.
                end
            endcase
        end
    end

    // Only the low IDX_W bits address the table; anything above must be zero.
    assign idx_ok_o    = ((index_i >> IDX_W) == '0);
    assign base_addr_o = index_i[IDX_W-1:0];

endmodule : lookup_cfg_hdr_decode

// File: rtl/lookup_table_writer.sv
// -----------------------------------------------------------------------------
// lookup_table_writer
//
// Control-path table writer for one RMT lookup. Control packets addressed to
// this stage/lookup are consumed and turned into TCAM (entry + mask pairs) or
// action-RAM (two-beat entries) writes; every other packet passes through to
// the next stage with one cycle of latency and all fields unchanged.
//
// Ports:
//   clk, rst_n           single rising-edge clock, async active-low reset
//   c_s_axis_t*          control stream in (data/user/keep/valid/last),
//                        never back-pressured
//   c_m_axis_t*          registered control stream out to the next stage
//   cam_we/addr/din/mask one-cycle TCAM write strobe, address, entry, mask
//   act_we/addr/din      one-cycle action-RAM write strobe, address, data
//
// Packet formats (one beat per cycle with tvalid=1; tvalid gaps hold state):
//   TCAM   : header, {entry, mask} x N      -- tlast on the last mask beat
//   action : header, {lo, hi} x N           -- tlast on the last hi beat
// Entry n is written at index[3:0] + n, wrapping inside the table.
// -----------------------------------------------------------------------------
module lookup_table_writer
    import lookup_table_writer_pkg::*;
#(
    parameter int STAGE_ID             = 0,
    parameter int LOOKUP_ID            = 2,
    parameter int C_S_AXIS_DATA_WIDTH  = 512,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int KEY_LEN              = 197,
    parameter int ACT_LEN              = 625,
    parameter int TBL_DEPTH            = 16
) (
    input  logic                                 clk,
    input  logic                                 rst_n,

    input  logic [C_S_AXIS_DATA_WIDTH-1:0]       c_s_axis_tdata,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]      c_s_axis_tuser,
    input  logic [(C_S_AXIS_DATA_WIDTH/8)-1:0]   c_s_axis_tkeep,
    input  logic                                 c_s_axis_tvalid,
    input  logic                                 c_s_axis_tlast,

    output logic [C_S_AXIS_DATA_WIDTH-1:0]       c_m_axis_tdata,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]      c_m_axis_tuser,
    output logic [(C_S_AXIS_DATA_WIDTH/8)-1:0]   c_m_axis_tkeep,
    output logic                                 c_m_axis_tvalid,
    output logic                                 c_m_axis_tlast,

    output logic                                 cam_we,
    output logic [$clog2(TBL_DEPTH)-1:0]         cam_addr,
    output logic [KEY_LEN-1:0]                   cam_din,
    output logic [KEY_LEN-1:0]                   cam_mask,

    output logic                                 act_we,
    output logic [$clog2(TBL_DEPTH)-1:0]         act_addr,
    output logic [ACT_LEN-1:0]                   act_din
);

    localparam int ADDR_W = $clog2(TBL_DEPTH);
    localparam int KEEP_W = C_S_AXIS_DATA_WIDTH / 8;
    localparam int HI_W   = ACT_LEN - C_S_AXIS_DATA_WIDTH;  // action bits in the hi beat

    // -------------------------------------------------------------------------
    // Header decode
    // -------------------------------------------------------------------------
    logic [HDR_MOD_ID_W-1:0] hdr_mod_id;
    logic [HDR_RESV_W-1:0]   hdr_resv;
    logic [HDR_INDEX_W-1:0]  hdr_index;
    logic                    hdr_claim;
    logic                    hdr_is_cam;
    logic                    hdr_idx_ok;
    logic [ADDR_W-1:0]       hdr_base;

    assign hdr_mod_id = c_s_axis_tdata[HDR_MOD_ID_LSB +: HDR_MOD_ID_W];
    assign hdr_resv   = c_s_axis_tdata[HDR_RESV_LSB   +: HDR_RESV_W];
    assign hdr_index  = c_s_axis_tdata[HDR_INDEX_LSB  +: HDR_INDEX_W];

    lookup_cfg_hdr_decode #(
        .STAGE_ID  (STAGE_ID),
        .LOOKUP_ID (LOOKUP_ID),
        .IDX_W     (ADDR_W)
    ) u_hdr_decode (
        .mod_id_i    (hdr_mod_id),
        .resv_i      (hdr_resv),
        .index_i     (hdr_index),
        .claim_o     (hdr_claim),
        .is_cam_o    (hdr_is_cam),
        .idx_ok_o    (hdr_idx_ok),
        .base_addr_o (hdr_base)
    );

    // -------------------------------------------------------------------------
    // State and registered outputs
    // -------------------------------------------------------------------------
    state_t                           state_q;
    logic [ADDR_W-1:0]                base_q;     // index[3:0] of the current packet
    logic [ADDR_W-1:0]                count_q;    // completed pairs / entries so far
    logic [KEY_LEN-1:0]               entry_q;    // TCAM entry waiting for its mask
    logic [C_S_AXIS_DATA_WIDTH-1:0]   act_lo_q;   // action low half waiting for hi

    logic [C_S_AXIS_DATA_WIDTH-1:0]   m_tdata_q;
    logic [C_S_AXIS_TUSER_WIDTH-1:0]  m_tuser_q;
    logic [KEEP_W-1:0]                m_tkeep_q;
    logic                             m_tvalid_q;
    logic                             m_tlast_q;

    logic                             cam_we_q;
    logic [ADDR_W-1:0]                cam_addr_q;
    logic [KEY_LEN-1:0]               cam_din_q;
    logic [KEY_LEN-1:0]               cam_mask_q;

    logic                             act_we_q;
    logic [ADDR_W-1:0]                act_addr_q;
    logic [ACT_LEN-1:0]               act_din_q;

    // A beat is forwarded when it is an unclaimed header or the body of an
    // unclaimed packet; claimed and dropped packets never reach the output.
    logic              fwd_beat;
    logic [ADDR_W-1:0] wr_addr;

    assign fwd_beat = c_s_axis_tvalid &&
                      (((state_q == ST_IDLE) && !hdr_claim) || (state_q == ST_FWD));

    // ADDR_W-bit sum: wraps from the last table slot back to 0.
    assign wr_addr = base_q + count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the wide staging and data registers are reset too, so the
            // outputs read as zero after reset and a packet cut short by reset
            // leaves nothing behind that a later write could pick up.
            state_q    <= ST_IDLE;
            base_q     <= '0;
            count_q    <= '0;
            entry_q    <= '0;
            act_lo_q   <= '0;
            m_tdata_q  <= '0;
            m_tuser_q  <= '0;
            m_tkeep_q  <= '0;
            m_tvalid_q <= 1'b0;
            m_tlast_q  <= 1'b0;
            cam_we_q   <= 1'b0;
            cam_addr_q <= '0;
            cam_din_q  <= '0;
            cam_mask_q <= '0;
            act_we_q   <= 1'b0;
            act_addr_q <= '0;
            act_din_q  <= '0;
        end else begin
            // NOTE: state is updated with non-blocking assignments only, so
            // every branch below reads the values from before this edge.
            cam_we_q   <= 1'b0;
            act_we_q   <= 1'b0;
            m_tvalid_q <= fwd_beat;

            // Data fields only move on forwarded beats; they hold otherwise.
            if (fwd_beat) begin
                m_tdata_q <= c_s_axis_tdata;
                m_tuser_q <= c_s_axis_tuser;
                m_tkeep_q <= c_s_axis_tkeep;
                m_tlast_q <= c_s_axis_tlast;
            end

            if (c_s_axis_tvalid) begin
                case (state_q)
                    ST_IDLE: begin
                        if (hdr_claim) begin
                            base_q  <= hdr_base;
                            count_q <= '0;
                            // A header that is also the last beat carries no
                            // entries, so it ends the packet right here.
                            if (c_s_axis_tlast) begin
                                state_q <= ST_IDLE;
                            end else if (!hdr_idx_ok) begin
                                state_q <= ST_DROP;
                            end else if (hdr_is_cam) begin
                                state_q <= ST_CAM_ENT;
                            end else begin
                                state_q <= ST_ACT_LO;
                            end
                        end else if (!c_s_axis_tlast) begin
                            state_q <= ST_FWD;
                        end
                    end

                    ST_FWD: begin
                        if (c_s_axis_tlast) begin
                            state_q <= ST_IDLE;
                        end
                    end

                    ST_CAM_ENT: begin
                        entry_q <= c_s_axis_tdata[KEY_LEN-1:0];
                        // tlast here leaves a half pair, which is discarded.
                        state_q <= c_s_axis_tlast ? ST_IDLE : ST_CAM_MSK;
                    end

                    ST_CAM_MSK: begin
                        cam_we_q   <= 1'b1;
                        cam_addr_q <= wr_addr;
                        cam_din_q  <= entry_q;
                        cam_mask_q <= c_s_axis_tdata[KEY_LEN-1:0];
                        count_q    <= count_q + ADDR_W'(1);
                        state_q    <= c_s_axis_tlast ? ST_IDLE : ST_CAM_ENT;
                    end

                    ST_ACT_LO: begin
                        act_lo_q <= c_s_axis_tdata;
                        // tlast here leaves a half entry, which is discarded.
                        state_q  <= c_s_axis_tlast ? ST_IDLE : ST_ACT_HI;
                    end

                    ST_ACT_HI: begin
                        act_we_q   <= 1'b1;
                        act_addr_q <= wr_addr;
                        act_din_q  <= {c_s_axis_tdata[HI_W-1:0], act_lo_q};
                        count_q    <= count_q + ADDR_W'(1);
                        state_q    <= c_s_axis_tlast ? ST_IDLE : ST_ACT_LO;
                    end

                    ST_DROP: begin
                        if (c_s_axis_tlast) begin
                            state_q <= ST_IDLE;
                        end
                    end

                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // -------------------------------------------------------------------------
    // Output wiring
    // -------------------------------------------------------------------------
    assign c_m_axis_tdata  = m_tdata_q;
    assign c_m_axis_tuser  = m_tuser_q;
    assign c_m_axis_tkeep  = m_tkeep_q;
    assign c_m_axis_tvalid = m_tvalid_q;
    assign c_m_axis_tlast  = m_tlast_q;

    assign cam_we   = cam_we_q;
    assign cam_addr = cam_addr_q;
    assign cam_din  = cam_din_q;
    assign cam_mask = cam_mask_q;

    assign act_we   = act_we_q;
    assign act_addr = act_addr_q;
    assign act_din  = act_din_q;

endmodule : lookup_table_writer

// File: tb/tb_lookup_table_writer.sv
// -----------------------------------------------------------------------------
// tb_lookup_table_writer
//
// Directed bench for lookup_table_writer (STAGE_ID 0, LOOKUP_ID 2). Each beat
// is driven just after a rising edge and the registered outputs it causes are
// sampled 1 ns after the following rising edge. Strobe and forward-beat
// counters sampled on falling edges catch writes or forwards that should not
// happen.
// -----------------------------------------------------------------------------
module tb_lookup_table_writer;

    logic         clk;
    logic         rst_n;

    logic [511:0] s_tdata;
    logic [127:0] s_tuser;
    logic [63:0]  s_tkeep;
    logic         s_tvalid;
    logic         s_tlast;

    logic [511:0] m_tdata;
    logic [127:0] m_tuser;
    logic [63:0]  m_tkeep;
    logic         m_tvalid;
    logic         m_tlast;

    logic         cam_we;
    logic [3:0]   cam_addr;
    logic [196:0] cam_din;
    logic [196:0] cam_mask;
    logic         act_we;
    logic [3:0]   act_addr;
    logic [624:0] act_din;

    int total = 0;
    int bad   = 0;

    int cam_cnt = 0;
    int act_cnt = 0;
    int fwd_cnt = 0;

    lookup_table_writer #(
        .STAGE_ID  (0),
        .LOOKUP_ID (2)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .c_s_axis_tdata  (s_tdata),
        .c_s_axis_tuser  (s_tuser),
        .c_s_axis_tkeep  (s_tkeep),
        .c_s_axis_tvalid (s_tvalid),
        .c_s_axis_tlast  (s_tlast),
        .c_m_axis_tdata  (m_tdata),
        .c_m_axis_tuser  (m_tuser),
        .c_m_axis_tkeep  (m_tkeep),
        .c_m_axis_tvalid (m_tvalid),
        .c_m_axis_tlast  (m_tlast),
        .cam_we          (cam_we),
        .cam_addr        (cam_addr),
        .cam_din         (cam_din),
        .cam_mask        (cam_mask),
        .act_we          (act_we),
        .act_addr        (act_addr),
        .act_din         (act_din)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count every strobe and forwarded beat, sampled mid-cycle.
    always @(negedge clk) begin
        if (cam_we === 1'b1)   cam_cnt++;
        if (act_we === 1'b1)   act_cnt++;
        if (m_tvalid === 1'b1) fwd_cnt++;
    end

    task automatic check(input string tag, input logic [639:0] obs, input logic [639:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of input, then sample 1 ns after the capturing edge.
    task automatic beat(input logic v, input logic [511:0] d, input logic l);
        s_tvalid = v;
        s_tdata  = d;
        s_tlast  = l;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [511:0] hdr(input logic [7:0] mid, input logic [3:0] resv,
                                         input logic [7:0] idx);
        logic [511:0] d;
        d = {16{32'h5A5A_0F0F}};
        d[375:368] = mid;
        d[383:380] = resv;
        d[391:384] = idx;
        return d;
    endfunction

    // Distinct value in every 32-bit word, so a wrong slice shows up.
    function automatic logic [511:0] pat(input logic [31:0] s);
        logic [511:0] d;
        for (int i = 0; i < 16; i++) begin
            d[i*32 +: 32] = s * 32'(i + 7) + 32'h1357_9BDF + {s[7:0], 24'h0};
        end
        return d;
    endfunction

    logic [511:0] e1, m1, e2, m2, e3, m3;
    logic [511:0] l1, h1, l2, h2, l3, h3, l4, h4;
    logic [511:0] f0, f1, f2, f3;
    logic [127:0] u0, u1;
    logic [63:0]  k0, k1;
    logic [624:0] exp_act;
    int           fwd_base;

    initial begin
        e1 = pat(1);  m1 = pat(2);  e2 = pat(3);  m2 = pat(4);
        l1 = pat(5);  h1 = pat(6);  l2 = pat(13); h2 = pat(14);
        e3 = pat(15); m3 = pat(16); l3 = pat(17); h3 = pat(18);
        l4 = pat(19); h4 = pat(20);
        f0 = hdr(8'h0A, 4'd0, 8'h03); f1 = pat(7); f2 = pat(8);
        f3 = hdr(8'h02, 4'd1, 8'h00);
        u0 = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_F00D_CAFE;
        u1 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
        k0 = 64'hFFFF_FFFF_FFFF_FFFF;
        k1 = 64'h0000_00FF_F0F0_0001;

        // ---------------- reset: outputs zero even with traffic present -----
        rst_n    = 1'b0;
        s_tuser  = u0;
        s_tkeep  = k0;
        s_tvalid = 1'b0;
        s_tdata  = '0;
        s_tlast  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        beat(1'b1, f0, 1'b1);
        check("rst m_tvalid", 640'(m_tvalid), 640'(1'b0));
        check("rst m_tdata",  640'(m_tdata),  640'(0));
        check("rst m_tuser",  640'(m_tuser),  640'(0));
        check("rst m_tkeep",  640'(m_tkeep),  640'(0));
        check("rst m_tlast",  640'(m_tlast),  640'(1'b0));
        check("rst cam_we",   640'(cam_we),   640'(1'b0));
        check("rst cam_addr", 640'(cam_addr), 640'(0));
        check("rst cam_din",  640'(cam_din),  640'(0));
        check("rst cam_mask", 640'(cam_mask), 640'(0));
        check("rst act_we",   640'(act_we),   640'(1'b0));
        check("rst act_addr", 640'(act_addr), 640'(0));
        check("rst act_din",  640'(act_din),  640'(0));
        rst_n = 1'b1;
        beat(1'b0, '0, 1'b0);

        // ---------------- TCAM: index 3, two pairs --------------------------
        beat(1'b1, hdr(8'h02, 4'd0, 8'h03), 1'b0);
        check("cam hdr not fwd", 640'(m_tvalid), 640'(1'b0));
        beat(1'b1, e1, 1'b0);
        check("cam e1 no we", 640'(cam_we), 640'(1'b0));
        beat(1'b1, m1, 1'b0);
        check("cam p1 we",   640'(cam_we),   640'(1'b1));
        check("cam p1 addr", 640'(cam_addr), 640'(4'd3));
        check("cam p1 din",  640'(cam_din),  640'(e1[196:0]));
        check("cam p1 mask", 640'(cam_mask), 640'(m1[196:0]));
        check("cam p1 no fwd", 640'(m_tvalid), 640'(1'b0));
        beat(1'b1, e2, 1'b0);
        check("cam we 1 cycle", 640'(cam_we),  640'(1'b0));
        check("cam din hold",   640'(cam_din), 640'(e1[196:0]));
        beat(1'b1, m2, 1'b1);
        check("cam p2 we",   640'(cam_we),   640'(1'b1));
        check("cam p2 addr", 640'(cam_addr), 640'(4'd4));
        check("cam p2 din",  640'(cam_din),  640'(e2[196:0]));
        check("cam p2 mask", 640'(cam_mask), 640'(m2[196:0]));

        // ---------------- action: back-to-back header, index 15, wrap -------
        beat(1'b1, hdr(8'h02, 4'd2, 8'h0F), 1'b0);
        check("act hdr cam_we low", 640'(cam_we),   640'(1'b0));
        check("act hdr mask hold",  640'(cam_mask), 640'(m2[196:0]));
        beat(1'b1, l1, 1'b0);
        beat(1'b0, pat(99), 1'b0);
        check("act gap no we", 640'(act_we), 640'(1'b0));
        beat(1'b1, h1, 1'b0);
        exp_act = {h1[112:0], l1};
        check("act e1 we",   640'(act_we),   640'(1'b1));
        check("act e1 addr", 640'(act_addr), 640'(4'd15));
        check("act e1 din",  640'(act_din),  640'(exp_act));
        beat(1'b1, l2, 1'b0);
        check("act we 1 cycle", 640'(act_we), 640'(1'b0));
        beat(1'b1, h2, 1'b1);
        exp_act = {h2[112:0], l2};
        check("act e2 we",   640'(act_we),   640'(1'b1));
        check("act e2 addr", 640'(act_addr), 640'(4'd0));
        check("act e2 din",  640'(act_din),  640'(exp_act));
        beat(1'b0, '0, 1'b0);
        check("cnt cam after tbl", 640'(cam_cnt), 640'(2));
        check("cnt act after tbl", 640'(act_cnt), 640'(2));
        check("cnt fwd after tbl", 640'(fwd_cnt), 640'(0));

        // ---------------- forwarding: foreign mod_id, gap cycle -------------
        fwd_base = fwd_cnt;
        s_tuser = u0; s_tkeep = k0;
        beat(1'b1, f0, 1'b0);
        check("fwd b0 valid", 640'(m_tvalid), 640'(1'b1));
        check("fwd b0 data",  640'(m_tdata),  640'(f0));
        check("fwd b0 user",  640'(m_tuser),  640'(u0));
        check("fwd b0 keep",  640'(m_tkeep),  640'(k0));
        check("fwd b0 last",  640'(m_tlast),  640'(1'b0));
        beat(1'b0, pat(50), 1'b0);
        check("fwd gap valid", 640'(m_tvalid), 640'(1'b0));
        s_tuser = u1;
        beat(1'b1, f1, 1'b0);
        check("fwd b1 valid", 640'(m_tvalid), 640'(1'b1));
        check("fwd b1 data",  640'(m_tdata),  640'(f1));
        check("fwd b1 user",  640'(m_tuser),  640'(u1));
        s_tkeep = k1;
        beat(1'b1, f2, 1'b1);
        check("fwd b2 valid", 640'(m_tvalid), 640'(1'b1));
        check("fwd b2 data",  640'(m_tdata),  640'(f2));
        check("fwd b2 keep",  640'(m_tkeep),  640'(k1));
        check("fwd b2 last",  640'(m_tlast),  640'(1'b1));
        // Own mod_id but an unknown table selector is forwarded too.
        beat(1'b1, f3, 1'b1);
        check("fwd resv1 valid", 640'(m_tvalid), 640'(1'b1));
        check("fwd resv1 data",  640'(m_tdata),  640'(f3));
        beat(1'b0, '0, 1'b0);
        check("cnt fwd beats", 640'(fwd_cnt - fwd_base), 640'(4));
        check("cnt cam no fwd writes", 640'(cam_cnt), 640'(2));
        check("cnt act no fwd writes", 640'(act_cnt), 640'(2));

        // ---------------- partial entry, header-only, bad index -------------
        fwd_base = fwd_cnt;
        beat(1'b1, hdr(8'h02, 4'd0, 8'h05), 1'b0);
        beat(1'b1, pat(9), 1'b1);
        check("partial no we", 640'(cam_we), 640'(1'b0));
        beat(1'b1, hdr(8'h02, 4'd2, 8'h01), 1'b1);
        check("hdr only no fwd", 640'(m_tvalid), 640'(1'b0));
        check("hdr only no we",  640'(act_we),   640'(1'b0));
        beat(1'b1, hdr(8'h02, 4'd0, 8'h12), 1'b0);
        beat(1'b1, pat(10), 1'b0);
        beat(1'b1, pat(11), 1'b0);
        beat(1'b1, pat(12), 1'b1);
        check("drop no fwd", 640'(m_tvalid), 640'(1'b0));
        beat(1'b1, hdr(8'h02, 4'd0, 8'h00), 1'b0);
        beat(1'b1, e3, 1'b0);
        beat(1'b1, m3, 1'b1);
        check("after drop we",   640'(cam_we),   640'(1'b1));
        check("after drop addr", 640'(cam_addr), 640'(4'd0));
        check("after drop din",  640'(cam_din),  640'(e3[196:0]));
        check("after drop mask", 640'(cam_mask), 640'(m3[196:0]));
        beat(1'b0, '0, 1'b0);
        check("cnt cam after drop", 640'(cam_cnt), 640'(3));
        check("cnt act after drop", 640'(act_cnt), 640'(2));
        check("cnt fwd after drop", 640'(fwd_cnt - fwd_base), 640'(0));

        // ---------------- reset during ACT_HI -------------------------------
        beat(1'b1, hdr(8'h02, 4'd2, 8'h05), 1'b0);
        beat(1'b1, l3, 1'b0);
        rst_n = 1'b0;
        beat(1'b1, h3, 1'b1);
        check("midrst act_we",   640'(act_we),   640'(1'b0));
        check("midrst act_addr", 640'(act_addr), 640'(0));
        check("midrst act_din",  640'(act_din),  640'(0));
        check("midrst cam_din",  640'(cam_din),  640'(0));
        check("midrst cam_mask", 640'(cam_mask), 640'(0));
        check("midrst m_tdata",  640'(m_tdata),  640'(0));
        check("midrst m_tvalid", 640'(m_tvalid), 640'(1'b0));
        rst_n = 1'b1;
        beat(1'b1, hdr(8'h02, 4'd2, 8'h07), 1'b0);
        check("post rst hdr no fwd", 640'(m_tvalid), 640'(1'b0));
        beat(1'b1, l4, 1'b0);
        beat(1'b1, h4, 1'b1);
        exp_act = {h4[112:0], l4};
        check("post rst act we",   640'(act_we),   640'(1'b1));
        check("post rst act addr", 640'(act_addr), 640'(4'd7));
        check("post rst act din",  640'(act_din),  640'(exp_act));
        beat(1'b0, '0, 1'b0);
        check("cnt act after rst", 640'(act_cnt), 640'(3));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_lookup_table_writer
